bcd_store: RTL and testbench
============================

# bcd_store

Sequencer that executes the CHIP-8 FX33 store: latches an 8-bit register value and the 12-bit index I, converts the value to hundreds/tens/ones with the combinational `bcd` converter, and writes the three digit bytes to main memory at I, I+1 and I+2 through a request/acknowledge write port. It sits between the CPU execute stage, which issues `start`, and the memory arbiter, which acknowledges each write.

## Interface
Parameters:
- none

Ports:
- `clk`  in  1  system clock; all state changes on rising edge
- `reset`  in  1  asynchronous, active-high; forces IDLE immediately
- `start`  in  1  begin an FX33 store; sampled only in IDLE
- `value`  in  8  VX value; latched on accepted `start`
- `addr`  in  12  index register I; latched on accepted `start`
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse after the third write is acknowledged
- `mem_addr`  out  12  write address
- `mem_wdata`  out  8  write data, digit zero-extended to 8 bits
- `mem_we`  out  1  write request; held until acknowledged
- `mem_ack`  in  1  arbiter accepted the current write this cycle
- `i_next`  out  12  updated index value (present only with macro, see Configuration)
- `i_we`  out  1  load strobe for `i_next` (present only with macro)

## Operation
- States: IDLE, WR0, WR1, WR2, DONE.
- IDLE: `start`=1 latches `value`→`val_q` and `addr`→`base_q`, then goes to WR0. `mem_ack` is ignored.
- WRn (n=0,1,2): `mem_we`=1, `mem_addr`=(`base_q`+n) mod 4096, `mem_wdata`= hundreds (n=0), tens (n=1), ones (n=2) of `val_q`.
  - `mem_ack`=1 sampled: advance to WR(n+1), or to DONE from WR2.
  - `mem_ack`=0: stay; address, data and `mem_we` remain stable.
- DONE: `done`=1 for one cycle, then IDLE.
- Digits come from the `bcd` converter driven by `val_q`, so they are stable for the whole operation. Hundreds is 0–2, tens and ones are 0–9. Upper bits of `mem_wdata` are 0.
- Address arithmetic is 12-bit and wraps. Example: `base_q`=0xFFE writes 0xFFE, 0xFFF, 0x000.
- `start` outside IDLE is ignored; there is no queueing.
- `value` and `addr` changes after acceptance have no effect.
- `mem_we` is 0 in IDLE and DONE. `mem_addr` and `mem_wdata` are 0 whenever `mem_we`=0.

## Timing
- Reset values: `busy`=0, `done`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `i_we`=0, `i_next`=0. State is IDLE and the latches are cleared.
- All outputs are registered or decoded from registered state only; there is no combinational path from `mem_ack` or `start` to any output.
- With `mem_ack` tied high, `start` accepted at edge 0 gives:
  - writes presented during cycles 1, 2, 3;
  - `done` high in cycle 4;
  - `busy` low and a new `start` accepted at edge 5.
- Each cycle of `mem_ack`=0 in a WR state adds one cycle of latency.
- A `reset` assertion mid-operation drops `mem_we` asynchronously. No further writes are issued. Writes already acknowledged are not undone.
- `start` asserted in the same cycle as `done` is ignored. It must be held or reissued once `busy` reads 0.

## Configuration
- `BCD_STORE_INC_I_EN` defined:
  - `i_next` and `i_we` ports exist.
  - In the DONE cycle, `i_we`=1 and `i_next`=(`base_q`+3) mod 4096 (original COSMAC VIP index-increment quirk).
  - Example: base 0xFFE gives `i_next`=0x001.
- Not defined: both ports are absent and I is never modified by this block.

## Test plan
- `value`=0xFF (255), `addr`=0x300, ack tied high → writes 0x300←2, 0x301←5, 0x302←5 in cycles 1–3; `done` pulses in cycle 4.
- `value`=0x00, `addr`=0xFFE → writes 0xFFE←0, 0xFFF←0, 0x000←0 (wrap); with macro, `i_we` pulses with `i_next`=0x001.
- `value`=0x09, ack held low 3 cycles on WR1 → WR1 address 0x(base+1) and data 0 held stable for 4 cycles; total latency from `start` to `done` = 7 cycles.
- `start` re-pulsed with `value`=0x63 during WR0 of a `value`=0x7B (123) store → only 1, 2, 3 are written; the second `start` is ignored.
- `reset` asserted during WR1 → `mem_we`, `busy` and `done` are 0 immediately; a following `start` with `value`=0x64 (100) writes 1, 0, 0 correctly.
- Sweep `value` 0–255 with random ack stalls → every triple equals the decimal digits of `value`, and exactly one `done` per `start`.

Source files
------------

// File: rtl/bcd_store.sv
// rtl/bcd_store.sv - CHIP-8 FX33 BCD store sequencer; optional BCD_STORE_INC_I_EN adds index write-back

// Combinational binary-to-decimal digit split of an 8-bit value.
module bcd (
    input  logic [7:0] value,
    output logic [7:0] hundreds,
    output logic [7:0] tens,
    output logic [7:0] ones
);

    // Constant divisors keep this a plain combinational divider network.
    assign hundreds = value / 8'd100;
    assign tens     = (value / 8'd10) % 8'd10;
    assign ones     = value % 8'd10;

endmodule

// Writes hundreds/tens/ones of a latched value to memory at I, I+1 and I+2.
module bcd_store (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  value,
    input  logic [11:0] addr,
    output logic        busy,
    output logic        done,
    output logic [11:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    input  logic        mem_ack
`ifdef BCD_STORE_INC_I_EN
    ,
    output logic [11:0] i_next,
    output logic        i_we
`endif
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WR0  = 3'd1,
        WR1  = 3'd2,
        WR2  = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [7:0]  val_q;
    logic [11:0] base_q;
    logic [7:0]  hundreds;
    logic [7:0]  tens;
    logic [7:0]  ones;

    // Digits depend only on the latched value, so they stay put for the whole store.
    bcd u_bcd (
        .value    (val_q),
        .hundreds (hundreds),
        .tens     (tens),
        .ones     (ones)
    );

    // State register; reset aborts any write in flight immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Operand latches load only when a start is accepted in IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            val_q  <= 8'd0;
            base_q <= 12'd0;
        end else if (state == IDLE && start) begin
            val_q  <= value;
            base_q <= addr;
        end
    end

    // Next-state: each write state waits for its acknowledge.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start)   next_state = WR0;
            WR0:     if (mem_ack) next_state = WR1;
            WR1:     if (mem_ack) next_state = WR2;
            WR2:     if (mem_ack) next_state = DONE;
            DONE:                 next_state = IDLE;
            default:              next_state = IDLE;
        endcase
    end

    // Outputs decoded from registered state only; address and data read 0 when no write is requested.
    always_comb begin
        busy      = (state != IDLE);
        done      = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = 12'd0;
        mem_wdata = 8'd0;
`ifdef BCD_STORE_INC_I_EN
        i_we      = 1'b0;
        i_next    = 12'd0;
`endif
        case (state)
            WR0: begin
                mem_we    = 1'b1;
                mem_addr  = base_q;
                mem_wdata = hundreds;
            end
            WR1: begin
                mem_we    = 1'b1;
                mem_addr  = base_q + 12'd1;
                mem_wdata = tens;
            end
            WR2: begin
                mem_we    = 1'b1;
                mem_addr  = base_q + 12'd2;
                mem_wdata = ones;
            end
            DONE: begin
                done   = 1'b1;
`ifdef BCD_STORE_INC_I_EN
                i_we   = 1'b1;
                i_next = base_q + 12'd3;
`endif
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_bcd_store.sv
// tb/tb_bcd_store.sv - randomized self-checking bench for bcd_store

module tb_bcd_store;

    logic        clk;
    logic        reset;
    logic        start;
    logic [7:0]  value;
    logic [11:0] addr;
    logic        busy;
    logic        done;
    logic [11:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic        mem_ack;
`ifdef BCD_STORE_INC_I_EN
    logic [11:0] i_next;
    logic        i_we;
`endif

    int total = 0;
    int bad   = 0;
    int starts = 0;
    int dones  = 0;

    bcd_store dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .value     (value),
        .addr      (addr),
        .busy      (busy),
        .done      (done),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_ack   (mem_ack)
`ifdef BCD_STORE_INC_I_EN
        ,
        .i_next    (i_next),
        .i_we      (i_we)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (done) dones++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    // mode: 0 ack always high, 1 stall a given stage a given number of cycles, 2 random stalls.
    // Entered and left at 1 time unit after a rising edge with the block idle.
    task automatic store(input logic [7:0] v, input logic [11:0] a, input int mode,
                         input int stall_stage, input int stall_cnt,
                         input bit repulse, input bit start_at_done, output int lat);
        logic [7:0]  dig [3];
        logic [11:0] ea;
        int n;
        int stalled;
        bit got;
        dig[0] = 8'(v / 100);
        dig[1] = 8'((v / 10) % 10);
        dig[2] = 8'(v % 10);
        n = 0;
        stalled = 0;
        got = 0;
        lat = 0;
        start = 1'b1;
        value = v;
        addr  = a;
        mem_ack = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
        starts++;
        start = 1'b0;
        value = 8'($urandom);
        addr  = 12'($urandom);
        for (int cyc = 1; cyc < 200 && !got; cyc++) begin
            if (n < 3) begin
                case (mode)
                    0: mem_ack = 1'b1;
                    1: begin
                        if (n == stall_stage && stalled < stall_cnt) begin
                            mem_ack = 1'b0;
                            stalled++;
                        end else begin
                            mem_ack = 1'b1;
                        end
                    end
                    default: mem_ack = ($urandom_range(0, 2) != 0);
                endcase
            end
            if (repulse && cyc == 1) begin
                start = 1'b1;
                value = 8'h63;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (n < 3) begin
                ea = a + 12'(n);
                check("we", mem_we, 1);
                check("addr", mem_addr, ea);
                check("wdata", mem_wdata, dig[n]);
                check("busy_wr", busy, 1);
                check("done_early", done, 0);
                if (mem_ack) n++;
            end else begin
                check("done", done, 1);
                check("busy_done", busy, 1);
                check("we_done", mem_we, 0);
                check("addr_done", mem_addr, 0);
                check("wdata_done", mem_wdata, 0);
`ifdef BCD_STORE_INC_I_EN
                check("i_we", i_we, 1);
                check("i_next", i_next, a + 12'd3);
`endif
                got = 1;
                lat = cyc;
                if (start_at_done) start = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!got) check("done_timeout", 0, 1);
        check("busy_after", busy, 0);
        check("done_after", done, 0);
        start = 1'b0;
        mem_ack = 1'b1;
    endtask

    initial begin
        int lat;
        reset   = 1'b1;
        start   = 1'b0;
        value   = 8'd0;
        addr    = 12'd0;
        mem_ack = 1'b1;
        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_we", mem_we, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
`ifdef BCD_STORE_INC_I_EN
        check("rst_i_we", i_we, 0);
        check("rst_i_next", i_next, 0);
`endif
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("idle_ack_ignored", busy, 0);

        store(8'hFF, 12'h300, 0, 0, 0, 0, 0, lat);
        check("lat_ack_high", lat, 4);

        store(8'h00, 12'hFFE, 0, 0, 0, 0, 0, lat);
        check("lat_wrap", lat, 4);

        store(8'h09, 12'h450, 1, 1, 3, 0, 0, lat);
        check("lat_stall3", lat, 7);

        store(8'h7B, 12'h010, 0, 0, 0, 1, 0, lat);
        check("lat_repulse", lat, 4);

        store(8'h2A, 12'h123, 0, 0, 0, 0, 1, lat);
        check("lat_start_at_done", lat, 4);

        start   = 1'b1;
        value   = 8'h7B;
        addr    = 12'h123;
        mem_ack = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
        check("pre_rst_addr", mem_addr, 12'h124);
        #2;
        reset = 1'b1;
        #1;
        check("arst_we", mem_we, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_addr", mem_addr, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        mem_ack = 1'b1;
        store(8'h64, 12'h200, 0, 0, 0, 0, 0, lat);
        check("lat_after_rst", lat, 4);

        for (int v = 0; v < 256; v++) begin
            store(8'(v), 12'($urandom), 2, 0, 0, 0, 0, lat);
        end

        @(negedge clk);
        check("done_count", dones, starts);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
